// File: rtl/data_cache_2way_if.sv
// Pipeline MEM-stage and RAM-arbiter signals of the 2-way data cache.
// The cache is the slave side; the pipeline/arbiter/testbench drive the master side.
interface data_cache_2way_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] value;
  logic [DATA_W-1:0] outData;
  logic              miss;
  logic              flush;
  logic              flushDone;
  logic [ADDR_W-1:0] addressToRAM;
  logic              writeRAM;
  logic              readRAM;
  logic [DATA_W-1:0] valueRAM;
  logic [DATA_W-1:0] outRAM;
  logic              ramReady;
  logic              dataUsingRAM;
  logic [CNT_W-1:0]  hitCount;
  logic [CNT_W-1:0]  missCount;

  modport slave (
    input  read, write, address, value, flush, outRAM, ramReady, dataUsingRAM,
    output outData, miss, flushDone, addressToRAM, writeRAM, readRAM, valueRAM,
           hitCount, missCount
  );

  modport master (
    output read, write, address, value, flush, outRAM, ramReady, dataUsingRAM,
    input  outData, miss, flushDone, addressToRAM, writeRAM, readRAM, valueRAM,
           hitCount, missCount
  );
endinterface

// File: rtl/data_cache_2way.sv
// 2-way set-associative write-back/write-allocate data cache, one word per line,
// with LRU replacement, whole-cache flush and saturating hit/miss counters.
module data_cache_2way #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETS   = 64,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clock,
  input logic               reset_n,
  data_cache_2way_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;
  localparam int unsigned PTR_W = IDX_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WB    = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_FSCAN = 3'd3;
  localparam logic [2:0] S_FWB   = 3'd4;

  logic [1:0]        valid_q [SETS];
  logic [1:0]        dirty_q [SETS];
  logic              lru_q   [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][2];
  logic [DATA_W-1:0] data_q  [SETS][2];

  logic [2:0]        state_q, state_d;
  logic              wr_q, wr_d, rd_q, rd_d, fd_q, fd_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;
  logic              vic_q, vic_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic              hit_inc, miss_inc, lru_we, lru_val, wr_hit, clr_dirty, fill_we;
  logic [IDX_W-1:0]  clr_set;
  logic              clr_way;

  // Lookup on the current request address
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_in;
  logic              hit0, hit1, hit, hit_way, victim, req, last;
  logic [IDX_W-1:0]  fset;
  logic              fway;
  logic [ADDR_W-1:0] fill_addr;
  logic              unused_addr_lsb;

  assign idx       = bus.address[2 +: IDX_W];
  assign tag_in    = bus.address[ADDR_W-1 -: TAG_W];
  assign fill_addr = {bus.address[ADDR_W-1:2], 2'b00};
  assign unused_addr_lsb = ^bus.address[1:0];
  assign hit0      = valid_q[idx][0] && (tag_q[idx][0] == tag_in);
  assign hit1      = valid_q[idx][1] && (tag_q[idx][1] == tag_in);
  assign hit       = hit0 || hit1;
  assign hit_way   = !hit0;
  assign victim    = !valid_q[idx][0] ? 1'b0 : (!valid_q[idx][1] ? 1'b1 : lru_q[idx]);
  assign req       = bus.read || bus.write;
  assign fset      = ptr_q[PTR_W-1:1];
  assign fway      = ptr_q[0];
  assign last      = (ptr_q == PTR_W'(2 * SETS - 1));

  assign bus.outData      = hit0 ? data_q[idx][0] : (hit1 ? data_q[idx][1] : '0);
  assign bus.miss         = (req && !(hit && (state_q == S_IDLE))) ||
                            (state_q == S_FSCAN) || (state_q == S_FWB);
  assign bus.writeRAM     = wr_q;
  assign bus.readRAM      = rd_q;
  assign bus.flushDone    = fd_q;
  assign bus.valueRAM     = val_q;
  assign bus.addressToRAM = addr_q;
  assign bus.hitCount     = hit_cnt_q;
  assign bus.missCount    = miss_cnt_q;

  // Next-state, registered-output and array-update strobes
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    fd_d      = 1'b0;
    val_d     = val_q;
    addr_d    = addr_q;
    vic_d     = vic_q;
    ptr_d     = ptr_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    lru_we    = 1'b0;
    lru_val   = 1'b0;
    wr_hit    = 1'b0;
    clr_dirty = 1'b0;
    clr_set   = idx;
    clr_way   = vic_q;
    fill_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            hit_inc = 1'b1;
            lru_we  = 1'b1;
            lru_val = !hit_way;
            wr_hit  = !bus.read;
          end else begin
            miss_inc = 1'b1;
            vic_d    = victim;
            if (dirty_q[idx][victim]) begin
              val_d   = data_q[idx][victim];
              addr_d  = {tag_q[idx][victim], idx, 2'b00};
              wr_d    = 1'b1;
              state_d = S_WB;
            end else begin
              addr_d  = fill_addr;
              rd_d    = 1'b1;
              state_d = S_FILL;
            end
          end
        end else if (bus.flush && !fd_q) begin
          // fd_q guard keeps a still-held flush from restarting on its done cycle
          ptr_d   = '0;
          state_d = S_FSCAN;
        end
      end
      S_WB: begin
        if (bus.dataUsingRAM) begin
          wr_d      = 1'b0;
          clr_dirty = 1'b1;
          rd_d      = 1'b1;
          addr_d    = fill_addr;
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.ramReady && bus.dataUsingRAM) begin
          fill_we = 1'b1;
          rd_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_FSCAN: begin
        if (valid_q[fset][fway] && dirty_q[fset][fway]) begin
          val_d   = data_q[fset][fway];
          addr_d  = {tag_q[fset][fway], fset, 2'b00};
          wr_d    = 1'b1;
          state_d = S_FWB;
        end else if (last) begin
          fd_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      S_FWB: begin
        if (bus.dataUsingRAM) begin
          wr_d      = 1'b0;
          clr_dirty = 1'b1;
          clr_set   = fset;
          clr_way   = fway;
          if (last) begin
            fd_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = S_FSCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      fd_q       <= 1'b0;
      val_q      <= '0;
      addr_q     <= '0;
      vic_q      <= 1'b0;
      ptr_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fd_q    <= fd_d;
      val_q   <= val_d;
      addr_q  <= addr_d;
      vic_q   <= vic_d;
      ptr_q   <= ptr_d;
      if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  // Line state bits; cleared by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        lru_q[s]   <= 1'b0;
      end
    end else begin
      if (lru_we)    lru_q[idx] <= lru_val;
      if (wr_hit)    dirty_q[idx][hit_way] <= 1'b1;
      if (clr_dirty) dirty_q[clr_set][clr_way] <= 1'b0;
      if (fill_we) begin
        valid_q[idx][vic_q] <= 1'b1;
        dirty_q[idx][vic_q] <= 1'b0;
      end
    end
  end

  // Tag and data storage; qualified by valid so no reset needed
  always_ff @(posedge clock) begin
    if (wr_hit) data_q[idx][hit_way] <= bus.value;
    if (fill_we) begin
      data_q[idx][vic_q] <= bus.outRAM;
      tag_q[idx][vic_q]  <= tag_in;
    end
  end
endmodule

// File: doc/data_cache_2way.md
Name: data_cache_2way

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache; one 32-bit word per line.
- Sits between the pipeline MEM stage and the shared RAM arbiter, using the same word handshake: readRAM/writeRAM, ramReady, dataUsingRAM.
- New over the direct-mapped generation: configurable set count, LRU replacement, a flush command, and saturating hit/miss counters.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width; also the line width.
- SETS, 64, number of sets; power of two, at least 2. IDX_W = log2(SETS).
- CNT_W, 16, width of the hit/miss counters.

Ports:
- clock  in  1  sole clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- read  in  1  load request; level, held until miss=0.
- write  in  1  store request; level, held until miss=0.
- address  in  ADDR_W  byte address; bits [1:0] ignored.
- value  in  DATA_W  store data.
- outData  out  DATA_W  load data; combinational from the hitting way.
- miss  out  1  stall to the pipeline.
- flush  in  1  flush request; level, held until flushDone.
- flushDone  out  1  one-cycle pulse when flush completes.
- addressToRAM  out  ADDR_W  RAM address.
- writeRAM  out  1  write-back strobe.
- readRAM  out  1  fill strobe.
- valueRAM  out  DATA_W  write-back data.
- outRAM  in  DATA_W  fill data.
- ramReady  in  1  RAM data valid.
- dataUsingRAM  in  1  arbiter grant to the data side.
- hitCount  out  CNT_W  saturating hit counter.
- missCount  out  CNT_W  saturating miss counter.

Behaviour:
Address decode and lookup:
- index = address[2+:IDX_W]; tag = address[ADDR_W-1:2+IDX_W].
- Per set: valid[2], dirty[2], tag[2], data[2], plus one lru bit naming the least-recently-used way.
- hit = a valid way whose tag matches; outData = that way's data, otherwise 0.
- miss = (read|write) && !(hit && stage==IDLE), OR stage is a FLUSH state.

Reset (reset_n low, asynchronous, also mid-transaction):
- All valid, dirty and lru bits cleared; stage=IDLE.
- writeRAM, readRAM, flushDone, valueRAM, both counters = 0, immediately. No RAM strobe survives a reset.

States:
- IDLE, priority order read > write > flush:
  - Read hit: lru = other way.
  - Write hit: data and dirty set in the hitting way, lru = other way. Written data is visible on outData the next cycle.
  - Miss: victim = first invalid way (way0 before way1), else the lru way.
  - Victim dirty: latch valueRAM = victim data, writeRAM=1, addressToRAM = {victim tag, index, 2'b00} -> WRITE_BACK.
  - Victim clean: readRAM=1 -> FILL.
  - flush with read=write=0: scan pointer = 0 -> FLUSH_SCAN.
- WRITE_BACK: hold the strobe and address until dataUsingRAM=1 is sampled. Then writeRAM=0, victim dirty=0, readRAM=1 -> FILL.
- FILL: addressToRAM = {address[ADDR_W-1:2], 2'b00}. On ramReady && dataUsingRAM:
  - install outRAM into the victim way; valid=1, tag written, dirty=0;
  - readRAM=0 -> IDLE.
  - The request is re-evaluated next cycle as a hit; a store therefore completes as a write hit.
- FLUSH_SCAN: the pointer walks the 2*SETS entries in order (set, way) = (0,0), (0,1), (1,0), ...
  - Entry valid and dirty: start a write-back as in IDLE -> FLUSH_WB.
  - Otherwise: advance. After the last entry: flushDone=1 for one cycle -> IDLE.
- FLUSH_WB: on dataUsingRAM, clear dirty (valid kept), advance -> FLUSH_SCAN.

Counters:
- missCount +1 on each IDLE->WRITE_BACK or IDLE->FILL transition.
- hitCount +1 on each IDLE cycle in which a request is serviced as a hit, including the post-fill retry.
- Both saturate at all-ones.

Boundary and simultaneous cases:
- read and write both high: treated as a read; value is ignored.
- Requests during a flush: stalled, not lost.
- flush while a miss is in progress: ignored until IDLE.
- flush with no dirty lines: completes in 2*SETS+1 cycles with no RAM traffic.
- ramReady without dataUsingRAM: ignored.

Test Plan:
- Reset, then read 0x100 -> miss=1, readRAM=1, addressToRAM=0x100. Return outRAM=0xDEADBEEF -> next cycle miss=0, outData=0xDEADBEEF, missCount=1, hitCount=1.
- Write 0x11111111 to 0x100, then read 0x100 -> no RAM strobes; outData=0x11111111. Read 0x100+4*SETS (same set) -> fills way1, way0 untouched.
- With SETS=64: after dirty 0x000, fill 0x100, reuse 0x100, read 0x200 -> way0 victim; writeRAM=1, addressToRAM=0x000, valueRAM = dirty data; then readRAM to 0x200.
- Hold dataUsingRAM=0 for 5 cycles during WRITE_BACK -> writeRAM, addressToRAM and valueRAM stable, miss=1 throughout.
- Dirty lines at set 3 way1 and set 10 way0, then flush -> exactly two write-backs in that order; flushDone pulses once; a re-flush produces zero writes.
- Pull reset_n low mid-FILL -> readRAM=0 immediately. After release, read of the same address misses again.
